// File: rtl/sd_clk_pkg.sv
// sd_clk_pkg: shared constants for the SD clock controller.
//   - FSM state encoding (S_OFF, S_START, S_WAIT, S_RUN)
//   - speed codes for identification mode and the default TRAN_SPEED
//   - period count width and default wait counter width
package sd_clk_pkg;

  localparam int CNT_W        = 16;
  localparam int WAIT_MAX_DEF = 64;
  localparam int WAIT_W       = $clog2(WAIT_MAX_DEF + 1);

  localparam logic [1:0] S_OFF   = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RUN   = 2'd3;

  localparam logic [7:0] ID_SPEED_CODE      = 8'h48;
  localparam logic [7:0] DEFAULT_TRAN_SPEED = 8'h32;

endpackage

// File: rtl/sd_clk_phase_gen.sv
// sd_clk_phase_gen: turns a period count into a registered SD clock.
//   High phase = count>>1 cycles, low phase = the rest (odd extra goes low).
//   Each run starts with a full low phase, so the first edge is rising.
// Ports:
//   clk, reset        system clock, async active-high reset
//   count             period in system cycles (>= 2 while running)
//   run               generator enabled (controller in its run state)
//   stop_req          request to park the clock low
//   sd_clk            SD clock output
//   sd_pos, sd_neg    strobes in the first cycle after a rise / fall
//   stopped           clock is parked low (stop request honoured)
// Macro SD_CLK_SAFE_STOP_EN: a stop request waits for the current high
// phase to finish instead of cutting it short.
module sd_clk_phase_gen
  import sd_clk_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] count,
  input  logic             run,
  input  logic             stop_req,
  output logic             sd_clk,
  output logic             sd_pos,
  output logic             sd_neg,
  output logic             stopped
);

  logic             sd_clk_q, sd_clk_d;
  logic             sd_pos_q, sd_pos_d;
  logic             sd_neg_q, sd_neg_d;
  logic [CNT_W-1:0] phase_cnt_q, phase_cnt_d;
  logic [CNT_W-1:0] high_len, low_len, phase_len;
  logic             hold_low;

  assign high_len  = count >> 1;
  assign low_len   = count - high_len;
  assign phase_len = sd_clk_q ? high_len : low_len;

`ifdef SD_CLK_SAFE_STOP_EN
  // A high phase in progress is allowed to complete; the clock parks once low.
  assign hold_low = !run || (stop_req && !sd_clk_q);
`else
  assign hold_low = !run || stop_req;
`endif

  assign stopped = hold_low;

  always_comb begin
    sd_clk_d    = sd_clk_q;
    sd_pos_d    = 1'b0;
    sd_neg_d    = 1'b0;
    phase_cnt_d = phase_cnt_q;
    if (hold_low) begin
      sd_clk_d    = 1'b0;
      sd_neg_d    = sd_clk_q;
      phase_cnt_d = '0;
    end else if (phase_cnt_q == phase_len - CNT_W'(1)) begin
      sd_clk_d    = !sd_clk_q;
      sd_pos_d    = !sd_clk_q;
      sd_neg_d    = sd_clk_q;
      phase_cnt_d = '0;
    end else begin
      phase_cnt_d = phase_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sd_clk_q    <= 1'b0;
      sd_pos_q    <= 1'b0;
      sd_neg_q    <= 1'b0;
      phase_cnt_q <= '0;
    end else begin
      sd_clk_q    <= sd_clk_d;
      sd_pos_q    <= sd_pos_d;
      sd_neg_q    <= sd_neg_d;
      phase_cnt_q <= phase_cnt_d;
    end
  end

  assign sd_clk = sd_clk_q;
  assign sd_pos = sd_pos_q;
  assign sd_neg = sd_neg_q;

endmodule

// File: rtl/sd_clk_ctrl.sv
// sd_clk_ctrl: sequences the shared divider and runs the SD card clock.
//   state   | meaning
//   S_OFF   | clock unconfigured, waiting for cfg_req
//   S_START | one cycle: div_start high, wait counter cleared
//   S_WAIT  | waiting for div_ok / div_err, bounded by WAIT_MAX cycles
//   S_RUN   | count latched, phase generator runs while clk_en=1
// Ports:
//   clk, reset                  system clock, async active-high reset
//   cfg_req, cfg_id, cfg_speed  reconfiguration request and speed selection
//   clk_en                      host request for sd_clk to run
//   div_start, div_speed        divider start pulse and speed code
//   div_ok, div_err, div_count  divider result
//   cfg_done, cfg_err           reconfiguration finished / sticky error
//   sd_clk, sd_pos, sd_neg      SD clock and edge strobes
//   clk_active, cur_count       clock running / latched period count
// Macro SD_CLK_SAFE_STOP_EN: stop requests wait for the high phase to end,
// and a cfg_req arriving in S_RUN is held pending until the clock is low.
module sd_clk_ctrl
  import sd_clk_pkg::*;
#(
  parameter int         WAIT_MAX  = 64,
  parameter logic [7:0] ID_SPEED  = ID_SPEED_CODE,
  parameter int         MIN_COUNT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_req,
  input  logic             cfg_id,
  input  logic [7:0]       cfg_speed,
  input  logic             clk_en,
  output logic             div_start,
  output logic [7:0]       div_speed,
  input  logic             div_ok,
  input  logic             div_err,
  input  logic [CNT_W-1:0] div_count,
  output logic             cfg_done,
  output logic             cfg_err,
  output logic             sd_clk,
  output logic             sd_pos,
  output logic             sd_neg,
  output logic             clk_active,
  output logic [CNT_W-1:0] cur_count
);

  localparam int WW = $clog2(WAIT_MAX + 1);

  logic [1:0]       state_q, state_d;
  logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
  logic [7:0]       div_speed_q, div_speed_d;
  logic [CNT_W-1:0] cur_count_q, cur_count_d;
  logic             cfg_done_q, cfg_done_d;
  logic             cfg_err_q, cfg_err_d;
  logic             pend_q, pend_d;
  logic             run, stop_req, stopped, timeout, fail;

  assign run      = (state_q == S_RUN);
  assign stop_req = !clk_en || cfg_req || pend_q;
  assign timeout  = (wait_cnt_q == WW'(WAIT_MAX - 1));

  sd_clk_phase_gen u_phase (
    .clk      (clk),
    .reset    (reset),
    .count    (cur_count_q),
    .run      (run),
    .stop_req (stop_req),
    .sd_clk   (sd_clk),
    .sd_pos   (sd_pos),
    .sd_neg   (sd_neg),
    .stopped  (stopped)
  );

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    div_speed_d = div_speed_q;
    cur_count_d = cur_count_q;
    cfg_done_d  = 1'b0;
    cfg_err_d   = cfg_err_q;
    pend_d      = pend_q;
    fail        = 1'b0;

    if (cfg_req) cfg_err_d = 1'b0;
    // Selection is captured only when the request is accepted; requests
    // during S_START/S_WAIT leave the divider's speed code untouched.
    if (cfg_req && (state_q == S_OFF || state_q == S_RUN))
      div_speed_d = cfg_id ? ID_SPEED : cfg_speed;

    case (state_q)
      S_OFF: begin
        if (cfg_req) state_d = S_START;
      end
      S_START: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        wait_cnt_d = wait_cnt_q + WW'(1);
        if (div_err) begin
          fail = 1'b1;
        end else if (div_ok) begin
          if (div_count >= CNT_W'(MIN_COUNT)) begin
            cur_count_d = div_count;
            cfg_done_d  = 1'b1;
            state_d     = S_RUN;
          end else begin
            fail = 1'b1;
          end
        end else if (timeout) begin
          fail = 1'b1;
        end
        if (fail) begin
          cur_count_d = '0;
          cfg_done_d  = 1'b1;
          cfg_err_d   = 1'b1;
          state_d     = S_OFF;
        end
      end
      default: begin
`ifdef SD_CLK_SAFE_STOP_EN
        pend_d = pend_q || cfg_req;
`endif
        if ((cfg_req || pend_q) && stopped) begin
          pend_d  = 1'b0;
          state_d = S_START;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_OFF;
      wait_cnt_q  <= '0;
      div_speed_q <= ID_SPEED;
      cur_count_q <= '0;
      cfg_done_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      div_speed_q <= div_speed_d;
      cur_count_q <= cur_count_d;
      cfg_done_q  <= cfg_done_d;
      cfg_err_q   <= cfg_err_d;
      pend_q      <= pend_d;
    end
  end

  assign div_start  = (state_q == S_START);
  assign div_speed  = div_speed_q;
  assign cur_count  = cur_count_q;
  assign cfg_done   = cfg_done_q;
  assign cfg_err    = cfg_err_q;
  assign clk_active = run && !stopped;

endmodule

// File: tb/tb_sd_clk_ctrl.sv
module tb_sd_clk_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_req = 1'b0, cfg_id = 1'b0, clk_en = 1'b0;
  logic [7:0]  cfg_speed = 8'h00;
  logic        div_ok = 1'b0, div_err = 1'b0;
  logic [15:0] div_count = 16'h0;
  logic        div_start, cfg_done, cfg_err, sd_clk, sd_pos, sd_neg, clk_active;
  logic [7:0]  div_speed;
  logic [15:0] cur_count;

  int n_chk = 0;
  int n_pass = 0;

  sd_clk_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_req    (cfg_req),
    .cfg_id     (cfg_id),
    .cfg_speed  (cfg_speed),
    .clk_en     (clk_en),
    .div_start  (div_start),
    .div_speed  (div_speed),
    .div_ok     (div_ok),
    .div_err    (div_err),
    .div_count  (div_count),
    .cfg_done   (cfg_done),
    .cfg_err    (cfg_err),
    .sd_clk     (sd_clk),
    .sd_pos     (sd_pos),
    .sd_neg     (sd_neg),
    .clk_active (clk_active),
    .cur_count  (cur_count)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse cfg_req, then wait (bounded) for the divider start pulse.
  task automatic do_cfg(input logic id, input logic [7:0] spd);
    int n;
    cfg_req = 1'b1; cfg_id = id; cfg_speed = spd;
    tick();
    cfg_req = 1'b0;
    n = 0;
    while (!div_start && n < 200) begin
      tick();
      n++;
    end
    check("start_seen", div_start, 1'b1);
  endtask

  // From S_START: n ticks, then present one divider response cycle.
  task automatic respond(input int n, input logic ok, input logic err, input logic [15:0] cnt);
    repeat (n) tick();
    div_ok = ok; div_err = err; div_count = cnt;
    tick();
    div_ok = 1'b0; div_err = 1'b0;
  endtask

  initial begin
    int lo, hi, n;

    // reset state
    #25;
    check("rst_div_start", div_start, 1'b0);
    check("rst_div_speed", div_speed, 8'h48);
    check("rst_sd_clk", sd_clk, 1'b0);
    check("rst_cur_count", cur_count, 16'd0);
    check("rst_active", clk_active, 1'b0);
    tick();
    reset = 1'b0;
    tick();

    // ID mode, divider answers 125 after 10 cycles
    clk_en = 1'b1;
    do_cfg(1'b1, 8'h00);
    check("id_speed", div_speed, 8'h48);
    tick();
    check("id_start_once", div_start, 1'b0);
    respond(9, 1'b1, 1'b0, 16'd125);
    check("id_done", cfg_done, 1'b1);
    check("id_count", cur_count, 16'd125);
    check("id_active", clk_active, 1'b1);
    check("id_err", cfg_err, 1'b0);
    lo = 1;
    while (lo < 300) begin tick(); if (sd_clk) break; lo++; end
    check("id_low1", lo, 63);
    check("id_pos", sd_pos, 1'b1);
    hi = 1;
    while (hi < 300) begin tick(); if (!sd_clk) break; hi++; end
    check("id_high", hi, 62);
    check("id_neg", sd_neg, 1'b1);
    lo = 1;
    while (lo < 300) begin tick(); if (sd_clk) break; lo++; end
    check("id_low2", lo, 63);

    // reconfigure while sd_clk is high (first high cycle)
    cfg_req = 1'b1; cfg_id = 1'b0; cfg_speed = 8'h32;
    tick();
    cfg_req = 1'b0;
`ifdef SD_CLK_SAFE_STOP_EN
    check("safe_hold_clk", sd_clk, 1'b1);
    check("safe_hold_active", clk_active, 1'b1);
    check("safe_no_start", div_start, 1'b0);
    hi = 2;
    while (hi < 300) begin tick(); if (!sd_clk) break; hi++; end
    check("safe_high", hi, 62);
    check("safe_neg", sd_neg, 1'b1);
    check("safe_start_late", div_start, 1'b0);
    tick();
    check("safe_start", div_start, 1'b1);
`else
    check("stop_clk", sd_clk, 1'b0);
    check("stop_neg", sd_neg, 1'b1);
    check("stop_start", div_start, 1'b1);
`endif
    check("tran_speed", div_speed, 8'h32);

    // ignored cfg_req in S_WAIT, then transfer count 2
    tick();
    cfg_req = 1'b1; cfg_id = 1'b1;
    tick();
    cfg_req = 1'b0;
    check("ign_start", div_start, 1'b0);
    check("ign_speed", div_speed, 8'h32);
    respond(1, 1'b1, 1'b0, 16'd2);
    check("tr_done", cfg_done, 1'b1);
    check("tr_count", cur_count, 16'd2);
    check("tr_clk0", sd_clk, 1'b0);
    tick();
    check("tr_first_rise", sd_clk, 1'b1);
    check("tr_pos", sd_pos, 1'b1);
    tick();
    check("tr_fall", sd_clk, 1'b0);
    check("tr_neg", sd_neg, 1'b1);
    tick();
    check("tr_rise2", sd_clk, 1'b1);

    // clk_en gating with sd_clk high
    clk_en = 1'b0;
    tick();
    check("gate_clk", sd_clk, 1'b0);
    check("gate_neg", sd_neg, 1'b1);
    check("gate_active", clk_active, 1'b0);
    tick();
    check("gate_hold", sd_clk, 1'b0);
    clk_en = 1'b1;
    tick();
    check("regate_rise", sd_clk, 1'b1);
    check("regate_pos", sd_pos, 1'b1);

    // div_err
    do_cfg(1'b1, 8'h00);
    respond(3, 1'b0, 1'b1, 16'd0);
    check("err_done", cfg_done, 1'b1);
    check("err_flag", cfg_err, 1'b1);
    check("err_count", cur_count, 16'd0);
    check("err_clk", sd_clk, 1'b0);
    tick();
    check("err_sticky", cfg_err, 1'b1);
    check("err_done_pulse", cfg_done, 1'b0);

    // cfg_req clears cfg_err; count 1 is rejected
    do_cfg(1'b0, 8'h32);
    check("err_clear", cfg_err, 1'b0);
    respond(2, 1'b1, 1'b0, 16'd1);
    check("min_err", cfg_err, 1'b1);
    check("min_count", cur_count, 16'd0);
    check("min_done", cfg_done, 1'b1);

    // simultaneous ok and err
    do_cfg(1'b1, 8'h00);
    respond(2, 1'b1, 1'b1, 16'd50);
    check("both_err", cfg_err, 1'b1);
    check("both_count", cur_count, 16'd0);
    check("both_active", clk_active, 1'b0);

    // timeout: 64 cycles in S_WAIT, cfg_done the cycle after
    do_cfg(1'b1, 8'h00);
    n = 0;
    while (!cfg_done && n < 200) begin tick(); n++; end
    check("to_cycles", n, 65);
    check("to_err", cfg_err, 1'b1);
    tick();
    check("to_done_pulse", cfg_done, 1'b0);
    div_ok = 1'b1; div_count = 16'd100;
    tick();
    div_ok = 1'b0;
    check("late_ok_count", cur_count, 16'd0);
    check("late_ok_done", cfg_done, 1'b0);

    // reset during S_WAIT
    do_cfg(1'b0, 8'h32);
    tick();
    #2 reset = 1'b1;
    #1;
    check("rw_speed", div_speed, 8'h48);
    check("rw_start", div_start, 1'b0);
    #2 reset = 1'b0;
    div_ok = 1'b1; div_count = 16'd100;
    tick();
    div_ok = 1'b0;
    check("rw_count", cur_count, 16'd0);
    check("rw_done", cfg_done, 1'b0);

    // reset during S_RUN with count 4 (2 low, 2 high)
    do_cfg(1'b0, 8'h20);
    respond(1, 1'b1, 1'b0, 16'd4);
    check("rr_count_pre", cur_count, 16'd4);
    tick();
    tick();
    check("rr_high", sd_clk, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("rr_clk", sd_clk, 1'b0);
    check("rr_count", cur_count, 16'd0);
    check("rr_active", clk_active, 1'b0);
    #2 reset = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
